// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer
//   Request front-end for the 32x8 lab memory. Requests arrive on a
//   valid/ready port, queue in an in-order FIFO, and are issued one per
//   cycle as single-cycle read or write strobes on the memory pins. Read
//   data comes back on a registered response port three clocks after the
//   read was accepted (when the FIFO was empty).
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   req_valid/req_ready       request handshake (ready = FIFO not full)
//   req_write/addr/wdata      request payload (wdata ignored for reads)
//   rsp_valid/addr/rdata      one-cycle read response, no backpressure
//   mem_read/mem_write        memory strobes, never high together
//   mem_addr/mem_data_in      memory address / write data (data is 0 on reads)
//   mem_data_out              memory read data, updated on the edge after mem_read
//   level                     FIFO occupancy
module mem_req_sequencer #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic [DATA_W-1:0]          req_wdata,
   output logic                       rsp_valid,
   output logic [ADDR_W-1:0]          rsp_addr,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       mem_read,
   output logic                       mem_write,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_data_in,
   input  logic [DATA_W-1:0]          mem_data_out,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ENT_W = 1 + ADDR_W + DATA_W;

   // FIFO storage: {write, addr, data}
   logic [ENT_W-1:0]  fifo_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [LVL_W-1:0]  level_reg;

   // read pipeline stage between the issue and the response capture
   logic              rd_pend_reg;
   logic [ADDR_W-1:0] rd_addr_reg;

   logic              push;
   logic              pop;
   logic              head_write;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   assign req_ready = (level_reg != LVL_W'(DEPTH));
   assign push      = req_valid && req_ready;
   // Pop decision uses the registered level only, so an entry pushed on
   // an edge can never be issued on that same edge.
   assign pop       = (level_reg != '0);
   assign level     = level_reg;

   assign {head_write, head_addr, head_data} = fifo_mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= {req_write, req_addr, req_wdata};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         level_reg   <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_data_in <= '0;
         rd_pend_reg <= 1'b0;
         rd_addr_reg <= '0;
         rsp_valid   <= 1'b0;
         rsp_addr    <= '0;
         rsp_rdata   <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end

         if (pop) begin
            rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
            mem_read    <= !head_write;
            mem_write   <= head_write;
            mem_addr    <= head_addr;
            mem_data_in <= head_write ? head_data : '0;
         end else begin
            // address/data hold their last values while idle
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
         end

         case ({push, pop})
            2'b10:   level_reg <= level_reg + LVL_W'(1);
            2'b01:   level_reg <= level_reg - LVL_W'(1);
            default: level_reg <= level_reg;
         endcase

         // The memory presents data on the edge ending the issue cycle;
         // it is captured one edge later together with the issued address.
         rd_pend_reg <= mem_read;
         rd_addr_reg <= mem_addr;
         rsp_valid   <= rd_pend_reg;
         if (rd_pend_reg) begin
            rsp_addr  <= rd_addr_reg;
            rsp_rdata <= mem_data_out;
         end
      end
   end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Testbench for mem_req_sequencer: drives requests at negedge, models the
// 32x8 memory, and checks strobes/responses against an acceptance-order
// scoreboard with a shadow memory.
module tb_mem_req_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [4:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [4:0] rsp_addr;
   logic [7:0] rsp_rdata;
   logic       mem_read;
   logic       mem_write;
   logic [4:0] mem_addr;
   logic [7:0] mem_data_in;
   logic [7:0] mem_data_out;
   logic [2:0] level;

   mem_req_sequencer #(.ADDR_W(5), .DATA_W(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .level(level)
   );

   always #5 clk = ~clk;

   // ---------------- memory model (the device downstream) ----------------
   logic [7:0] env_mem [32];
   always @(posedge clk) begin
      if (mem_write) env_mem[mem_addr] <= mem_data_in;
      if (mem_read)  mem_data_out <= env_mem[mem_addr];
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      bit         w;
      logic [4:0] a;
      logic [7:0] d;
      int         acc;   // cycle count right after the accepting edge
   } ent_t;

   ent_t       iq[$];        // expected issues, acceptance order
   ent_t       rq[$];        // expected read responses
   logic [7:0] shadow [32];  // memory as seen by accepted requests
   logic [7:0] committed [32]; // memory after observed (expected) writes

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int wr_seen = 0;
   int rsp_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // monitor at negedge: away from the active edge
   always @(negedge clk) begin
      ent_t e;
      if (rst) begin
         chk("rst_quiet", 32'({mem_read, mem_write, rsp_valid}), 32'd0);
      end else begin
         chk("strobe_excl", 32'(mem_read && mem_write), 32'd0);
         if (mem_read || mem_write) begin
            if (mem_write) wr_seen++;
            if (iq.size() == 0) begin
               chk("spurious_issue", 32'd1, 32'd0);
            end else begin
               e = iq.pop_front();
               chk("issue_kind", 32'(mem_write), 32'(e.w));
               chk("issue_addr", 32'(mem_addr), 32'(e.a));
               chk("issue_data", 32'(mem_data_in), e.w ? 32'(e.d) : 32'd0);
               chk("issue_lat", 32'(cyc), 32'(e.acc + 1));
               if (e.w) committed[e.a] = e.d;
            end
         end
         if (rsp_valid) begin
            rsp_seen++;
            if (rq.size() == 0) begin
               chk("spurious_rsp", 32'd1, 32'd0);
            end else begin
               e = rq.pop_front();
               chk("rsp_addr", 32'(rsp_addr), 32'(e.a));
               chk("rsp_data", 32'(rsp_rdata), 32'(e.d));
               chk("rsp_lat", 32'(cyc), 32'(e.acc + 3));
            end
         end
      end
   end

   // apply one request for one cycle; records acceptance in the model
   task automatic drive(input bit v, input bit w, input logic [4:0] a, input logic [7:0] d);
      ent_t e;
      @(negedge clk);
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      #1;
      if (v && req_ready) begin
         e.w = w; e.a = a; e.d = d; e.acc = cyc + 1;
         iq.push_back(e);
         if (w) begin
            shadow[a] = d;
         end else begin
            e.d = shadow[a];
            rq.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 5'd0, 8'd0);
   endtask

   // reset just after an edge: everything queued or in flight is lost
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      req_valid = 1'b0;
      iq.delete();
      rq.delete();
      for (int i = 0; i < 32; i++) shadow[i] = committed[i];
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("post_rst_level", 32'(level), 32'd0);
      chk("post_rst_ready", 32'(req_ready), 32'd1);
   endtask

   typedef struct {
      bit         v;
      bit         w;
      logic [4:0] a;
      logic [7:0] d;
      logic [2:0] exp_level;
      bit         exp_ready;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int w0, r0;
      // back-to-back burst: level observed when each row is applied
      tbl[0] = '{1'b1, 1'b1, 5'd1, 8'h11, 3'd0, 1'b1};
      tbl[1] = '{1'b1, 1'b1, 5'd2, 8'h22, 3'd1, 1'b1};
      tbl[2] = '{1'b1, 1'b0, 5'd1, 8'h00, 3'd1, 1'b1};
      tbl[3] = '{1'b1, 1'b1, 5'd3, 8'h33, 3'd1, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 5'd2, 8'h00, 3'd1, 1'b1};
      tbl[5] = '{1'b1, 1'b0, 5'd3, 8'h00, 3'd1, 1'b1};
      tbl[6] = '{1'b0, 1'b0, 5'd0, 8'h00, 3'd1, 1'b1};
      tbl[7] = '{1'b0, 1'b0, 5'd0, 8'h00, 3'd0, 1'b1};

      for (int i = 0; i < 32; i++) begin
         env_mem[i]   = 8'h00;
         shadow[i]    = 8'h00;
         committed[i] = 8'h00;
      end
      rst = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_data", 32'(mem_data_in), 32'd0);
      chk("rst_rsp", 32'({rsp_addr, rsp_rdata}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("rel_ready", 32'(req_ready), 32'd1);

      // single write then read of address 5
      w0 = wr_seen; r0 = rsp_seen;
      drive(1'b1, 1'b1, 5'd5, 8'hA5);
      drive(1'b1, 1'b0, 5'd5, 8'h00);
      idle(6);
      chk("single_wr_count", 32'(wr_seen - w0), 32'd1);
      chk("single_rsp_count", 32'(rsp_seen - r0), 32'd1);

      // table-driven burst
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d);
         chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].exp_level));
         chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      end
      idle(5);

      // streaming: 32 writes of ~i then 32 reads
      r0 = rsp_seen;
      for (int i = 0; i < 32; i++) drive(1'b1, 1'b1, 5'(i), ~8'(i));
      for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 5'(i), 8'h00);
      idle(6);
      chk("stream_rsp_count", 32'(rsp_seen - r0), 32'd32);

      // wrap: steady push/pop keeps level at 1
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, i[0], 5'(20 + i / 2), 8'(8'h40 + i));
         chk("wrap_level", 32'(level), (i == 0) ? 32'd0 : 32'd1);
      end
      idle(6);

      // reset in the middle of three queued writes
      drive(1'b1, 1'b1, 5'd10, 8'h01);
      drive(1'b1, 1'b1, 5'd11, 8'h02);
      drive(1'b1, 1'b1, 5'd12, 8'h03);
      do_reset();
      idle(2);
      r0 = rsp_seen;
      drive(1'b1, 1'b0, 5'd10, 8'h00);
      drive(1'b1, 1'b0, 5'd11, 8'h00);
      drive(1'b1, 1'b0, 5'd12, 8'h00);
      idle(6);
      chk("rst_readback_count", 32'(rsp_seen - r0), 32'd3);

      // random traffic against the scoreboard
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 8'($urandom));
      end
      idle(8);

      chk("drain_issue_q", 32'(iq.size()), 32'd0);
      chk("drain_rsp_q", 32'(rq.size()), 32'd0);
      chk("final_level", 32'(level), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
